fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of the control unit. Maintains the program counter and issues word reads to instruction memory over a req/ack handshake. Registers each returned 16-bit instruction, splits it into the opcode (driven straight into the control unit's 4-bit opcode input) and operand fields, and presents it downstream with a valid/ready handshake. Taken branches from the execute stage redirect the PC and flush any in-flight or held instruction.

## Interface
- PC_W, 8: program counter / instruction address width (word addressed).
- RESET_PC, 0: PC value loaded on reset.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  read request; held with stable imem_addr until imem_ack.
- imem_addr  output  PC_W  word address of requested instruction.
- imem_ack  input  1  read complete; imem_rdata valid this cycle.
- imem_rdata  input  16  instruction word.
- instr_valid  output  1  instruction fields valid.
- instr_ready  input  1  downstream accepts instruction this cycle.
- opcode  output  4  imem_rdata[15:12]; feeds control unit opcode.
- rd, rs  output  4 each  imem_rdata[11:8], [7:4].
- imm  output  4  imem_rdata[3:0].
- instr_pc  output  PC_W  address the held instruction was fetched from.
- branch_taken  input  1  one-cycle redirect pulse from execute.
- branch_target  input  PC_W  new PC when branch_taken=1.
- halted  output  1  halt reached (FETCH_HALT_EN only; else tied 0).

## Operation
- One-entry output register (OR). States: FETCH, STALL, FLUSH, HALT.
- Reset: pc=RESET_PC, state=FETCH, instr_valid=0, imem_req=0, opcode/rd/rs/imm/instr_pc=0, halted=0.
- FETCH: imem_req=1 when OR empty, or OR full and instr_ready=1 this cycle (may be combinational on instr_ready, but once asserted stays high until ack). imem_addr=pc.
- On imem_ack in FETCH (no branch): load OR from imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+1 (mod 2^PC_W, PC_W'(all ones) wraps to 0).
- OR full and instr_ready=0 and no request outstanding: STALL; imem_req=0; OR fields stable. Leaves to FETCH on instr_ready=1.
- Consumption: valid&ready with no ack same cycle -> instr_valid<=0.
- branch_taken (priority over all else except reset): instr_valid<=0 next cycle; pc<=branch_target. If request outstanding and imem_ack=0 -> FLUSH: keep imem_req/imem_addr stable until ack, discard data, then FETCH from target. If imem_ack=1 same cycle -> data discarded, go FETCH. A valid&ready handshake coincident with branch_taken counts as consumed.
- Branch in FLUSH: pc<=new target, remain FLUSH.
- Reset mid-request: request abandoned immediately (imem_req=0 next cycle); any late ack ignored.

## Timing
- Zero-wait memory (ack in request cycle), instr_ready held 1: first instr_valid 2 cycles after reset deasserts; thereafter one instruction per cycle.
- Fetch latency: instr_valid rises the cycle after imem_ack.
- Branch: target address on imem_addr the cycle after branch_taken (FETCH) or the cycle after pending ack (FLUSH); no stale instruction ever asserts instr_valid after the branch cycle.
- All outputs registered except imem_req (registered state ANDed with instr_ready path).

## Configuration
- FETCH_HALT_EN defined: opcode 4'hF is HALT. Upon loading it into OR, fetching stops (state HALT, imem_req=0); HALT instruction still delivered downstream; halted=1 from the cycle after it is consumed. Only reset or branch_taken leaves HALT.
- Undefined: 4'hF is an ordinary opcode, HALT state absent, halted tied 0.

## Test plan
- Reset, zero-wait memory returning mem[a]={a[3:0],4'h1,4'h2,4'h3}, ready=1 -> opcodes 0,1,2,... on consecutive cycles, instr_pc 0,1,2.
- instr_ready low 5 cycles while instr at pc=3 held -> fields stable, imem_req=0, pc=4 fetched only after ready returns.
- Memory acks 3 cycles after req; branch_taken target=0x40 during wait -> old data discarded, next imem_addr=0x40, next valid instr_pc=0x40.
- PC_W=4, start pc=14 -> fetches 14,15,0,1.
- Reset asserted mid-request -> imem_req=0 next cycle, instr_valid=0, first fetch at RESET_PC.
- FETCH_HALT_EN, mem[2]=16'hF000 -> instrs 0,1,2 delivered, no req after addr 2, halted=1; branch_taken to 0 resumes.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory, decoded-instruction and branch-redirect signals of the fetch stage
interface fetch_unit_if #(parameter int PC_W = 8);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [15:0]     imem_rdata;
   logic            instr_valid;
   logic            instr_ready;
   logic [3:0]      opcode;
   logic [3:0]      rd;
   logic [3:0]      rs;
   logic [3:0]      imm;
   logic [PC_W-1:0] instr_pc;
   logic            branch_taken;
   logic [PC_W-1:0] branch_target;
   logic            halted;
   modport master (
      output imem_req, imem_addr, instr_valid, opcode, rd, rs, imm, instr_pc, halted,
      input  imem_ack, imem_rdata, instr_ready, branch_taken, branch_target
   );
   modport slave (
      input  imem_req, imem_addr, instr_valid, opcode, rd, rs, imm, instr_pc, halted,
      output imem_ack, imem_rdata, instr_ready, branch_taken, branch_target
   );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC + imem req/ack fetch into a one-entry output register; FETCH_HALT_EN makes opcode F halt fetching
module fetch_unit #(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input logic         clk,
   input logic         reset,
   fetch_unit_if.master bus
);
`ifdef FETCH_HALT_EN
   typedef enum logic [1:0] {FETCH, STALL, FLUSH, HALT} state_t;
   logic r_halted;
`else
   typedef enum logic [1:0] {FETCH, STALL, FLUSH} state_t;
`endif
   state_t          r_state;
   logic [PC_W-1:0] r_pc, r_addr, r_ipc;
   logic [15:0]     r_instr;
   logic            r_valid, r_out, r_live;
   logic            w_new, w_req, w_ack, w_take, w_pend;
   // r_live keeps the first cycle after reset quiet so no request overlaps reset
   assign w_new  = r_live && !bus.branch_taken && (r_state == FETCH || r_state == STALL) && (!r_valid || bus.instr_ready);
   assign w_req  = r_out || w_new;
   assign w_ack  = w_req && bus.imem_ack;
   assign w_take = r_valid && bus.instr_ready;
   assign w_pend = w_req && !bus.imem_ack;
   // state, PC, outstanding-request flag and output register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= FETCH;
         r_pc    <= RESET_PC;
         r_addr  <= RESET_PC;
         r_ipc   <= '0;
         r_instr <= '0;
         r_valid <= 1'b0;
         r_out   <= 1'b0;
         r_live  <= 1'b0;
`ifdef FETCH_HALT_EN
         r_halted <= 1'b0;
`endif
      end else begin
         r_live <= 1'b1;
         if (bus.branch_taken) begin
            r_pc    <= bus.branch_target;
            r_valid <= 1'b0;
            r_out   <= w_pend;
            r_state <= w_pend ? FLUSH : FETCH;
            r_addr  <= w_pend ? r_addr : bus.branch_target;
`ifdef FETCH_HALT_EN
            r_halted <= 1'b0;
`endif
         end else if (r_state == FLUSH) begin
            if (bus.imem_ack) begin
               r_out   <= 1'b0;
               r_state <= FETCH;
               r_addr  <= r_pc;
            end
         end
`ifdef FETCH_HALT_EN
         else if (r_state == HALT) begin
            if (w_take) begin
               r_valid  <= 1'b0;
               r_halted <= 1'b1;
            end
         end
`endif
         else if (w_ack) begin
            r_instr <= bus.imem_rdata;
            r_ipc   <= r_pc;
            r_valid <= 1'b1;
            r_pc    <= r_pc + PC_W'(1);
            r_addr  <= r_pc + PC_W'(1);
            r_out   <= 1'b0;
`ifdef FETCH_HALT_EN
            r_state <= (bus.imem_rdata[15:12] == 4'hF) ? HALT : FETCH;
`else
            r_state <= FETCH;
`endif
         end else begin
            r_out   <= w_req;
            r_valid <= w_take ? 1'b0 : r_valid;
            r_state <= (r_valid && !bus.instr_ready && !w_req) ? STALL : FETCH;
         end
      end
   end
   assign bus.imem_req    = w_req;
   assign bus.imem_addr   = r_addr;
   assign bus.instr_valid = r_valid;
   assign bus.opcode      = r_instr[15:12];
   assign bus.rd          = r_instr[11:8];
   assign bus.rs          = r_instr[7:4];
   assign bus.imm         = r_instr[3:0];
   assign bus.instr_pc    = r_ipc;
`ifdef FETCH_HALT_EN
   assign bus.halted      = r_halted;
`else
   assign bus.halted      = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven and directed checks of fetch_unit (8-bit PC instance plus a 4-bit wrap instance)
module tb_fetch_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   delay = 0;
   int   cnt = 0;
   logic ack_force = 1'b0;
   logic halt_mode = 1'b0;
   fetch_unit_if #(.PC_W(8)) b8();
   fetch_unit_if #(.PC_W(4)) b4();
   fetch_unit #(.PC_W(8), .RESET_PC(8'd0))  u8 (.clk(clk), .reset(reset), .bus(b8.master));
   fetch_unit #(.PC_W(4), .RESET_PC(4'd14)) u4 (.clk(clk), .reset(reset), .bus(b4.master));
   always #5 clk = ~clk;
   function automatic logic [15:0] mem_word(input logic [7:0] a);
      return (halt_mode && a == 8'd2) ? 16'hF000 : {a[3:0], 12'h123};
   endfunction
   // memory model: ack after `delay` waiting cycles, or forced ack for the late-ack case
   always_ff @(posedge clk) cnt <= (b8.imem_req && !b8.imem_ack) ? cnt + 1 : 0;
   assign b8.imem_ack   = ack_force || (b8.imem_req && cnt >= delay);
   assign b8.imem_rdata = mem_word(b8.imem_addr);
   assign b4.imem_ack   = b4.imem_req;
   assign b4.imem_rdata = {b4.imem_addr, 12'h123};
   assign b4.instr_ready   = 1'b1;
   assign b4.branch_taken  = 1'b0;
   assign b4.branch_target = 4'd0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask
   task automatic tick();
      @(negedge clk);
   endtask
   typedef struct {
      logic       rdy;
      logic       req;
      logic [7:0] addr;
      logic       vld;
      logic [3:0] op;
      logic [7:0] ipc;
      logic [3:0] addr4;
      logic [3:0] ipc4;
   } vec_t;
   vec_t tv[13];
   initial begin
      tv[0]  = '{1'b1, 1'b0, 8'd0, 1'b0, 4'd0, 8'd0, 4'd14, 4'd0};
      tv[1]  = '{1'b1, 1'b1, 8'd0, 1'b0, 4'd0, 8'd0, 4'd14, 4'd0};
      tv[2]  = '{1'b1, 1'b1, 8'd1, 1'b1, 4'd0, 8'd0, 4'd15, 4'd14};
      tv[3]  = '{1'b1, 1'b1, 8'd2, 1'b1, 4'd1, 8'd1, 4'd0,  4'd15};
      tv[4]  = '{1'b1, 1'b1, 8'd3, 1'b1, 4'd2, 8'd2, 4'd1,  4'd0};
      tv[5]  = '{1'b0, 1'b0, 8'd4, 1'b1, 4'd3, 8'd3, 4'd2,  4'd1};
      tv[6]  = '{1'b0, 1'b0, 8'd4, 1'b1, 4'd3, 8'd3, 4'd3,  4'd2};
      tv[7]  = '{1'b0, 1'b0, 8'd4, 1'b1, 4'd3, 8'd3, 4'd4,  4'd3};
      tv[8]  = '{1'b0, 1'b0, 8'd4, 1'b1, 4'd3, 8'd3, 4'd5,  4'd4};
      tv[9]  = '{1'b0, 1'b0, 8'd4, 1'b1, 4'd3, 8'd3, 4'd6,  4'd5};
      tv[10] = '{1'b1, 1'b1, 8'd4, 1'b1, 4'd3, 8'd3, 4'd7,  4'd6};
      tv[11] = '{1'b1, 1'b1, 8'd5, 1'b1, 4'd4, 8'd4, 4'd8,  4'd7};
      tv[12] = '{1'b1, 1'b1, 8'd6, 1'b1, 4'd5, 8'd5, 4'd9,  4'd8};
      b8.instr_ready   = 1'b1;
      b8.branch_taken  = 1'b0;
      b8.branch_target = 8'd0;
      tick();
      tick();
      #1;
      chk("rst req", 32'(b8.imem_req), 0);
      chk("rst valid", 32'(b8.instr_valid), 0);
      chk("rst opcode", 32'(b8.opcode), 0);
      chk("rst instr_pc", 32'(b8.instr_pc), 0);
      chk("rst halted", 32'(b8.halted), 0);
      chk("rst addr4", 32'(b4.imem_addr), 14);
      for (int k = 0; k < 13; k++) begin
         tick();
         reset = 1'b0;
         b8.instr_ready = tv[k].rdy;
         #1;
         chk($sformatf("row%0d req", k), 32'(b8.imem_req), 32'(tv[k].req));
         chk($sformatf("row%0d addr", k), 32'(b8.imem_addr), 32'(tv[k].addr));
         chk($sformatf("row%0d valid", k), 32'(b8.instr_valid), 32'(tv[k].vld));
         chk($sformatf("row%0d opcode", k), 32'(b8.opcode), 32'(tv[k].op));
         chk($sformatf("row%0d instr_pc", k), 32'(b8.instr_pc), 32'(tv[k].ipc));
         chk($sformatf("row%0d addr4", k), 32'(b4.imem_addr), 32'(tv[k].addr4));
         chk($sformatf("row%0d instr_pc4", k), 32'(b4.instr_pc), 32'(tv[k].ipc4));
      end
      chk("row12 rd", 32'(b8.rd), 1);
      chk("row12 rs", 32'(b8.rs), 2);
      chk("row12 imm", 32'(b8.imm), 3);
      tick(); delay = 3; #1;
      chk("slow req", 32'(b8.imem_req), 1);
      chk("slow addr", 32'(b8.imem_addr), 7);
      chk("slow ipc", 32'(b8.instr_pc), 6);
      tick(); #1;
      chk("wait valid", 32'(b8.instr_valid), 0);
      chk("wait addr", 32'(b8.imem_addr), 7);
      tick(); b8.branch_taken = 1'b1; b8.branch_target = 8'h40; #1;
      chk("br req", 32'(b8.imem_req), 1);
      chk("br addr", 32'(b8.imem_addr), 7);
      tick(); b8.branch_taken = 1'b0; #1;
      chk("flush req", 32'(b8.imem_req), 1);
      chk("flush addr", 32'(b8.imem_addr), 7);
      chk("flush ack", 32'(b8.imem_ack), 1);
      chk("flush valid", 32'(b8.instr_valid), 0);
      tick(); delay = 0; #1;
      chk("target addr", 32'(b8.imem_addr), 32'h40);
      chk("target req", 32'(b8.imem_req), 1);
      chk("target valid0", 32'(b8.instr_valid), 0);
      tick(); delay = 3; #1;
      chk("target valid", 32'(b8.instr_valid), 1);
      chk("target ipc", 32'(b8.instr_pc), 32'h40);
      chk("target next addr", 32'(b8.imem_addr), 32'h41);
      tick(); reset = 1'b1; #1;
      chk("pre-rst req", 32'(b8.imem_req), 1);
      tick(); reset = 1'b0; ack_force = 1'b1; #1;
      chk("midrst req", 32'(b8.imem_req), 0);
      chk("midrst valid", 32'(b8.instr_valid), 0);
      chk("midrst addr", 32'(b8.imem_addr), 0);
      tick(); ack_force = 1'b0; delay = 0; #1;
      chk("late ack valid", 32'(b8.instr_valid), 0);
      chk("restart req", 32'(b8.imem_req), 1);
      chk("restart addr", 32'(b8.imem_addr), 0);
      tick(); #1;
      chk("restart valid", 32'(b8.instr_valid), 1);
      chk("restart ipc", 32'(b8.instr_pc), 0);
`ifdef FETCH_HALT_EN
      tick(); reset = 1'b1; halt_mode = 1'b1;
      tick();
      tick(); reset = 1'b0;
      tick();
      tick(); tick(); #1;
      chk("h addr", 32'(b8.imem_addr), 2);
      tick(); #1;
      chk("h valid", 32'(b8.instr_valid), 1);
      chk("h opcode", 32'(b8.opcode), 32'hF);
      chk("h ipc", 32'(b8.instr_pc), 2);
      chk("h req", 32'(b8.imem_req), 0);
      chk("h halted0", 32'(b8.halted), 0);
      tick(); #1;
      chk("h consumed", 32'(b8.instr_valid), 0);
      chk("h req2", 32'(b8.imem_req), 0);
      chk("h halted", 32'(b8.halted), 1);
      tick(); b8.branch_taken = 1'b1; b8.branch_target = 8'd0; #1;
      chk("h req3", 32'(b8.imem_req), 0);
      tick(); b8.branch_taken = 1'b0; #1;
      chk("resume req", 32'(b8.imem_req), 1);
      chk("resume addr", 32'(b8.imem_addr), 0);
      chk("resume halted", 32'(b8.halted), 0);
`else
      for (int j = 1; j <= 16; j++) begin
         tick(); #1;
         chk($sformatf("run%0d ipc", j), 32'(b8.instr_pc), 32'(j));
         if (j >= 15) begin
            chk($sformatf("run%0d opcode", j), 32'(b8.opcode), (j == 15) ? 32'hF : 32'h0);
            chk($sformatf("run%0d valid", j), 32'(b8.instr_valid), 1);
            chk($sformatf("run%0d req", j), 32'(b8.imem_req), 1);
            chk($sformatf("run%0d halted", j), 32'(b8.halted), 0);
         end
      end
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
